// File: rtl/mmu_pkg.sv
// MMU shared types: TLB<->PTW request/response structs and the PTW arbiter state.
// Arbiter search order is selected by the PTW_ARB_RR_EN macro (see ptw_arb_multi).
package mmu_pkg;

    localparam int PTW_ARB_MAX_REQ = 8;
    localparam int VPN_W           = 27;
    localparam int PPN_W           = 44;

    typedef struct packed {
        logic             valid;
        logic [VPN_W-1:0] vpn;
    } ptw_req_t;

    typedef struct packed {
        ptw_req_t req;
    } tlb_ptw_comm_t;

    typedef struct packed {
        logic             valid;
        logic             error;
        logic [1:0]       level;
        logic [PPN_W-1:0] ppn;
    } ptw_resp_t;

    typedef struct packed {
        ptw_resp_t  resp;
        logic       ptw_ready;
        logic [7:0] ptw_status;
        logic       invalidate_tlb;
    } ptw_tlb_comm_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } ptw_arb_state_e;

endpackage

// File: rtl/ptw_rr_pick.sv
// Combinational find-first over an N-bit request vector, searching upward from
// i_start and wrapping modulo N. Fixed-priority callers tie i_start to 0.
module ptw_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_start,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IDX_W:0] w_sum;

    // Rotate so bit 0 of w_rot is the requester at i_start.
    assign w_dbl = {i_req, i_req};
    assign w_rot = N'(w_dbl >> i_start);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_valid = 1'b1;
                w_sum   = {1'b0, i_start} + (IDX_W+1)'(k);
                if (w_sum >= (IDX_W+1)'(N)) begin
                    w_sum = w_sum - (IDX_W+1)'(N);
                end
                o_idx = w_sum[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/ptw_arb_multi.sv
// N-requester arbiter in front of the single page-table walker, one request slot per TLB.
// Define PTW_ARB_RR_EN for round-robin search; otherwise lowest index wins.
module ptw_arb_multi
    import mmu_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int REQ_IDX_W = $clog2(NUM_REQ)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  tlb_ptw_comm_t [NUM_REQ-1:0]         tlb_ptw_comm_i,
    output ptw_tlb_comm_t [NUM_REQ-1:0]         ptw_tlb_comm_o,
    input  ptw_tlb_comm_t                       ptw_tlb_comm_i,
    output tlb_ptw_comm_t                       tlb_ptw_comm_o,
    output logic                                busy_o,
    output logic [REQ_IDX_W-1:0]                grant_idx_o
);

    ptw_arb_state_e              r_state;
    ptw_arb_state_e              w_state_nxt;
    logic [REQ_IDX_W-1:0]        r_owner;
    logic [NUM_REQ-1:0]          r_slot_full;
    tlb_ptw_comm_t [NUM_REQ-1:0] r_slot;

    logic [REQ_IDX_W-1:0]        w_start;
    logic                        w_pick_valid;
    logic [REQ_IDX_W-1:0]        w_pick_idx;
    logic                        w_grant;
    logic                        w_inval;
    logic                        w_resp_done;
    logic [NUM_REQ-1:0]          w_ready;
    logic                        w_unused_ptw_ready;

    assign w_inval            = ptw_tlb_comm_i.invalidate_tlb;
    assign w_resp_done        = (r_state == SERVE) && ptw_tlb_comm_i.resp.valid;
    assign w_unused_ptw_ready = ptw_tlb_comm_i.ptw_ready;

`ifdef PTW_ARB_RR_EN
    logic [REQ_IDX_W-1:0] r_rr_ptr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rr_ptr <= '0;
        end else if (w_resp_done) begin
            r_rr_ptr <= (r_owner == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
        end
    end

    assign w_start = r_rr_ptr;
`else
    assign w_start = '0;
`endif

    ptw_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (REQ_IDX_W)
    ) u_pick (
        .i_req   (r_slot_full),
        .i_start (w_start),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_grant        = 1'b0;
        tlb_ptw_comm_o = '0;
        busy_o         = 1'b0;
        grant_idx_o    = '0;
        case (r_state)
            IDLE: begin
                // An invalidate cycle never issues; the slots are being flushed.
                if (w_pick_valid && !w_inval) begin
                    w_grant        = 1'b1;
                    tlb_ptw_comm_o = r_slot[w_pick_idx];
                    busy_o         = 1'b1;
                    grant_idx_o    = w_pick_idx;
                    w_state_nxt    = SERVE;
                end
            end
            SERVE: begin
                tlb_ptw_comm_o = r_slot[r_owner];
                busy_o         = 1'b1;
                grant_idx_o    = r_owner;
                if (ptw_tlb_comm_i.resp.valid) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            w_ready[i]                       = !r_slot_full[i] && !w_inval;
            ptw_tlb_comm_o[i].resp           = '0;
            ptw_tlb_comm_o[i].ptw_ready      = w_ready[i];
            ptw_tlb_comm_o[i].ptw_status     = ptw_tlb_comm_i.ptw_status;
            ptw_tlb_comm_o[i].invalidate_tlb = w_inval;
            if ((r_state == SERVE) && (r_owner == REQ_IDX_W'(i))) begin
                ptw_tlb_comm_o[i].resp = ptw_tlb_comm_i.resp;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_owner     <= '0;
            r_slot_full <= '0;
            r_slot      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner <= w_pick_idx;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (tlb_ptw_comm_i[i].req.valid && w_ready[i]) begin
                    r_slot[i]      <= tlb_ptw_comm_i[i];
                    r_slot_full[i] <= 1'b1;
                end else if (w_resp_done && (r_owner == REQ_IDX_W'(i))) begin
                    r_slot_full[i] <= 1'b0;
                end else if (w_inval && !((r_state == SERVE) && (r_owner == REQ_IDX_W'(i)))) begin
                    // The in-flight owner keeps its slot until its response lands.
                    r_slot_full[i] <= 1'b0;
                end
            end
        end
    end

endmodule
